// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file geometry for the writeback arbiter
package regfile_wb_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_arb_sel.sv
// wb_arb_sel: combinational one-hot grant, searching upward from start and wrapping
module wb_arb_sel #(
    parameter int N = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     grant
);
    // scanning offsets downward lets the closest valid to start overwrite the rest
    always_comb begin
        grant = '0;
        for (int k = N - 1; k >= 0; k--)
            if (valid[(int'(start) + k) % N]) grant = N'(1) << ((int'(start) + k) % N);
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shared RF write port, pending-write scoreboard, hazard flags (WB_RR_ARB_EN: round-robin)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PEND_W = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]       req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          alloc_valid,
    input  logic [REG_ADDR_W-1:0]         alloc_addr,
    output logic                          alloc_ready,
    input  logic [REG_ADDR_W-1:0]         rs1_addr,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          wb_we,
    output logic [REG_ADDR_W-1:0]         wb_waddr,
    output logic [XLEN-1:0]               wb_wdata
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0]     pend [NUM_REGS];
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      start;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [XLEN-1:0]       win_data;
    logic                  hs, do_alloc, do_rel;
`ifdef WB_RR_ARB_EN
    logic [PTR_W-1:0] rr_ptr, win_idx;
    assign start = rr_ptr;
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) win_idx = PTR_W'(i);
    end
    always_ff @(posedge clk) begin
        if (!rst) rr_ptr <= '0;
        else if (hs) rr_ptr <= PTR_W'((int'(win_idx) + 1) % NUM_REQ);
    end
`else
    assign start = '0;
`endif
    wb_arb_sel #(.N(NUM_REQ)) u_sel (.valid(req_valid), .start(start), .grant(grant));
    assign req_ready = rst ? grant : '0;
    assign hs = |req_ready;
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) begin
                win_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                win_data = req_data[i*XLEN +: XLEN];
            end
    end
    assign alloc_ready = rst & ((alloc_addr == REG_ZERO) | (pend[alloc_addr] != PEND_MAX));
    assign do_alloc = alloc_valid & alloc_ready & (alloc_addr != REG_ZERO);
    assign do_rel = hs & (win_addr != REG_ZERO);
    assign rs1_busy = (rs1_addr != REG_ZERO) & (pend[rs1_addr] != '0);
    assign rs2_busy = (rs2_addr != REG_ZERO) & (pend[rs2_addr] != '0);
    // simultaneous alloc and release of one register cancel; release never underflows
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
            wb_we <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (do_alloc && alloc_addr == REG_ADDR_W'(r) && !(do_rel && win_addr == REG_ADDR_W'(r)))
                    pend[r] <= pend[r] + PEND_W'(1);
                else if (do_rel && win_addr == REG_ADDR_W'(r) && !(do_alloc && alloc_addr == REG_ADDR_W'(r)) && pend[r] != '0)
                    pend[r] <= pend[r] - PEND_W'(1);
            end
            wb_we <= do_rel;
            if (do_rel) begin
                wb_waddr <= win_addr;
                wb_wdata <= win_data;
            end
        end
    end
    assert property (@(posedge clk) disable iff (!rst)
        !(do_rel && pend[win_addr] == '0 && !(do_alloc && alloc_addr == win_addr)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed + randomized checks against a scoreboard model (honours WB_RR_ARB_EN)
module tb_regfile_wb_arbiter;
    localparam int N = 3;
    localparam int PMAX = 3;
    logic clk = 0, rst = 0;
    logic [N-1:0] req_valid = '0;
    logic [N*5-1:0] req_addr = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic alloc_valid = 0, alloc_ready, rs1_busy, rs2_busy, wb_we;
    logic [4:0] alloc_addr = '0, rs1_addr = '0, rs2_addr = '0, wb_waddr;
    logic [31:0] wb_wdata;
    int vectors = 0, miscompares = 0;
    int cnt [32];
    int ptr = 0, last_g = -1;
    logic e_we = 0;
    logic [4:0] e_waddr = '0;
    logic [31:0] e_wdata = '0;
    logic [N-1:0] obs_ready;
    logic obs_ar, obs_busy1;
    logic [4:0] alloc_q [$];
    logic [4:0] pool [5] = '{5'd0, 5'd5, 5'd7, 5'd9, 5'd12};

    regfile_wb_arbiter #(.NUM_REQ(N), .PEND_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int s);
        for (int k = 0; k < N; k++)
            if (v[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic set_req(int i, logic v, logic [4:0] a, logic [31:0] d);
        req_valid[i] = v;
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
    endtask

    // one clock: check combinational outputs mid-cycle, advance the model, check write stage
    task automatic step();
        int g;
        logic ar;
        logic [4:0] a;
        #4;
        g = rst ? pick(req_valid, ptr) : -1;
        ar = rst && (alloc_addr == 0 || cnt[alloc_addr] < PMAX);
        obs_ready = req_ready;
        obs_ar = alloc_ready;
        obs_busy1 = rs1_busy;
        check("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'(1 << g));
        check("alloc_ready", 32'(alloc_ready), 32'(ar));
        if (rst) begin
            check("rs1_busy", 32'(rs1_busy), 32'(rs1_addr != 0 && cnt[rs1_addr] != 0));
            check("rs2_busy", 32'(rs2_busy), 32'(rs2_addr != 0 && cnt[rs2_addr] != 0));
        end
        @(posedge clk);
        if (!rst) begin
            for (int r = 0; r < 32; r++) cnt[r] = 0;
            ptr = 0;
            e_we = 0;
            e_waddr = '0;
            e_wdata = '0;
        end else begin
            e_we = 0;
            if (g >= 0) begin
                a = req_addr[g*5 +: 5];
                if (a != 0) begin
                    e_we = 1;
                    e_waddr = a;
                    e_wdata = req_data[g*32 +: 32];
                    cnt[a]--;
                end
`ifdef WB_RR_ARB_EN
                ptr = (g + 1) % N;
`endif
            end
            if (alloc_valid && ar && alloc_addr != 0) begin
                cnt[alloc_addr]++;
                alloc_q.push_back(alloc_addr);
            end
        end
        last_g = g;
        #1;
        check("wb_we", 32'(wb_we), 32'(e_we));
        check("wb_waddr", 32'(wb_waddr), 32'(e_waddr));
        check("wb_wdata", wb_wdata, e_wdata);
    endtask

    task automatic idle();
        req_valid = '0;
        alloc_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        repeat (2) step();
        rst = 1;
        alloc_q.delete();
    endtask

    initial begin
        // reset with every input asserted
        for (int i = 0; i < N; i++) set_req(i, 1, 5'd0, 32'hA5A5_0000 + i);
        alloc_valid = 1;
        alloc_addr = 5;
        repeat (2) begin
            step();
            check("rst_ready", 32'(obs_ready), 0);
            check("rst_alloc_ready", 32'(obs_ar), 0);
        end
        rst = 1;
        idle();
        for (int i = 0; i < 16; i++) begin
            rs1_addr = 5'(2 * i);
            rs2_addr = 5'(2 * i + 1);
            step();
        end
        // fixed order from a fresh reset: 0,1,2 in both modes
        for (int k = 1; k <= 3; k++) begin
            alloc_valid = 1;
            alloc_addr = 5'(k);
            step();
        end
        alloc_valid = 0;
        for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 1), 32'h1000 + i);
        for (int k = 0; k < 3; k++) begin
            step();
            check("prio_grant", 32'(obs_ready), 32'(1 << k));
            check("prio_waddr", 32'(wb_waddr), 32'(k + 1));
            if (last_g >= 0) req_valid[last_g] = 0;
        end
        // allocate x5, then requester 1 writes it
        idle();
        rs1_addr = 5;
        alloc_valid = 1;
        alloc_addr = 5;
        step();
        alloc_valid = 0;
        set_req(1, 1, 5'd5, 32'hDEAD_BEEF);
        step();
        check("x5_busy", 32'(obs_busy1), 1);
        check("x5_grant", 32'(obs_ready), 32'b010);
        check("x5_wb", {26'd0, wb_we, wb_waddr}, {26'd0, 1'b1, 5'd5});
        check("x5_wdata", wb_wdata, 32'hDEAD_BEEF);
        idle();
        step();
        check("x5_busy_after", 32'(obs_busy1), 0);
        // saturate x7, release, then alloc+release together
        do_reset();
        alloc_valid = 1;
        alloc_addr = 7;
        repeat (3) step();
        step();
        check("sat_full", 32'(obs_ar), 0);
        alloc_valid = 0;
        set_req(0, 1, 5'd7, 32'h7777_0001);
        step();
        req_valid[0] = 0;
        alloc_valid = 1;
        set_req(0, 1, 5'd7, 32'h7777_0002);
        step();
        check("sat_after_rel", 32'(obs_ar), 1);
        check("sat_same_grant", 32'(obs_ready), 32'b001);
        req_valid[0] = 0;
        step();
        check("sat_count2", 32'(obs_ar), 1);
        step();
        check("sat_full_again", 32'(obs_ar), 0);
        // x0 write and allocation
        idle();
        rs1_addr = 0;
        alloc_valid = 1;
        alloc_addr = 0;
        set_req(2, 1, 5'd0, 32'h1234);
        step();
        check("x0_grant", 32'(obs_ready), 32'b100);
        check("x0_alloc_ready", 32'(obs_ar), 1);
        check("x0_we", 32'(wb_we), 0);
        check("x0_busy", 32'(obs_busy1), 0);
        // continuous x0 requests, granted requester re-presents
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 5'd0, 32'h2000 + i);
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef WB_RR_ARB_EN
            check("arb_order", 32'(obs_ready), 32'(1 << (k % 3)));
`else
            check("arb_order", 32'(obs_ready), 32'b001);
`endif
            if (last_g >= 0) set_req(last_g, 1, 5'd0, $urandom());
        end
        // randomized traffic: writes only claim earlier accepted allocations, in order
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (last_g >= 0) req_valid[last_g] = 0;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    if (alloc_q.size() > 0 && $urandom_range(0, 4) != 0) set_req(i, 1, alloc_q.pop_front(), $urandom());
                    else if ($urandom_range(0, 5) == 0) set_req(i, 1, 5'd0, $urandom());
                end
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_addr = pool[$urandom_range(0, 4)];
            rs1_addr = pool[$urandom_range(0, 4)];
            rs2_addr = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : pool[$urandom_range(0, 4)];
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/waddr/wdata) among NUM_REQ writeback requesters, e.g. ALU, load unit and multi-cycle mul/div.
- Holds a per-register pending-write scoreboard: decode allocates the destination register, and the writeback handshake releases it.
- Drives the issue-stall signals for rs1/rs2/rd hazards.
- Sits between the execute/memory writeback paths and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- PEND_W, 2, width of each per-register pending counter; at most 2^PEND_W-1 outstanding writes per register.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  requester i has a write pending
- req_addr  in  NUM_REQ*5  destination register per requester (slice i = bits 5i+4:5i)
- req_data  in  NUM_REQ*32  write data per requester
- req_ready  out  NUM_REQ  grant/accept for requester i
- alloc_valid  in  1  decode issues an instruction that writes alloc_addr
- alloc_addr  in  5  destination register being allocated
- alloc_ready  out  1  allocation accepted; low means stall issue
- rs1_addr  in  5  source-1 query address
- rs2_addr  in  5  source-2 query address
- rs1_busy  out  1  rs1 has an outstanding write
- rs2_busy  out  1  rs2 has an outstanding write
- wb_we  out  1  register-file write enable
- wb_waddr  out  5  register-file write address
- wb_wdata  out  32  register-file write data

Behaviour:
- Reset: while rst==0 at a clk edge, all pending counters clear to 0, wb_we=0, wb_waddr=0, wb_wdata=0, and the round-robin pointer resets to 0. While rst==0, req_ready=0 and alloc_ready=0.
- Arbitration is combinational, at most one grant per cycle. req_ready[i]=1 only for the selected valid requester; with no valid requests, all ready bits are 0.
- Fixed priority (default): the lowest index wins.
- Handshake for requester i: req_valid[i] & req_ready[i]. A requester holds valid, addr and data stable until accepted; the arbiter never drops a valid request.
- Write stage latency is 1 cycle. On a handshake the next edge registers wb_we=1 with the winner's addr/data. With no handshake the next edge sets wb_we=0 and wb_waddr/wb_wdata hold their values.
- x0 writes: the handshake completes, but wb_we stays 0 and the scoreboard is untouched.
- alloc_ready = rst & (alloc_addr==0 | pend[alloc_addr] != max). When alloc_valid & alloc_ready & alloc_addr!=0, pend[alloc_addr] increments at the next edge.
- Release: on a handshake with addr!=0, pend[addr] decrements at the next edge.
- Same register allocated and released in one cycle: the counter is unchanged.
- Release with pend==0 is a protocol error. The counter stays 0 (no underflow), and a simulation-only assertion fires.
- rsN_busy = (rsN_addr!=0) & (pend[rsN_addr]!=0). It is combinational from the counters, so it drops the cycle after the handshake. At that point the write is in wb_*, and the register-file bypass supplies the data.
- Allocation is in-order with respect to requesters; the arbiter does not match releases to specific allocations.

Optional Feature:
- Macro: WB_RR_ARB_EN.
- Defined: round-robin arbitration. The search starts at rr_ptr. After each handshake, rr_ptr moves to (winner+1) mod NUM_REQ; otherwise it holds.
- Undefined: fixed priority with requester 0 highest, and no rr_ptr register.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and the constant REG_ZERO=5'd0.
- Sub-module wb_arb_sel: a combinational one-hot grant from valid bits plus an optional start pointer.
- The counter array and the write-stage registers stay in the top module.

Test Plan:
- Reset: with rst=0 for 2 cycles and all req_valid=1 -> req_ready=0, wb_we=0. With alloc_valid=1 held -> rs1_busy=0 for every rs1_addr after release.
- Allocate x5 -> rs1_addr=5 gives rs1_busy=1. Requester 1 writes x5=0xDEADBEEF -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0xDEADBEEF, rs1_busy=0.
- Fixed priority: valid=3'b111 for 3 cycles, each holding until accepted -> grants in order 0,1,2, and wb_waddr follows in the same order one cycle later.
- Round-robin (WB_RR_ARB_EN defined): valid=3'b111 held continuously, each requester re-presenting after accept -> grants cycle 0,1,2,0.
- Saturation: allocate x7 three times with PEND_W=2 -> fourth alloc gives alloc_ready=0. Release once -> alloc_ready=1. Allocate and release x7 in the same cycle -> count unchanged.
- x0: allocate x0 and write x0=0x1234 -> handshake completes, wb_we=0, alloc_ready=1, rs1_busy(0)=0.
